// File: rtl/fifo_pkg.sv
// Shared defaults, width helper and error-cause encoding for the flow-controlled FIFO.
// Depth is assumed to be a power of two so pointers wrap naturally.
package fifo_pkg;

  localparam int DEF_DATA_W = 6;
  localparam int DEF_DEPTH  = 8;

  // Occupancy must represent 0..DEPTH inclusive, hence one bit more than the pointer.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_OVF  = 2'd1,
    ERR_UDF  = 2'd2
  } err_cause_e;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage, one write port and one registered read port; read data valid the edge after rd_en.
// No backpressure here: the caller only enables ports for accepted push/pop; the array itself has no reset.
module fifo_mem #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_dat
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_dat_q;
  logic [DATA_W-1:0] rd_dat_d;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_dat;
    end
  end

  // Output register holds its value when no read is accepted.
  always_comb begin
    rd_dat_d = rd_dat_q;
    if (rd_en) begin
      rd_dat_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rd_dat_q <= '0;
    end else begin
      rd_dat_q <= rd_dat_d;
    end
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/fifo_flow_ctrl.sv
// Synchronous FIFO with threshold flags and sticky error; write-to-read 1 cycle, registered read data + valid.
// Raises pausa at count >= almost_full_th; pushes while full without a pop are dropped and flagged.
module fifo_flow_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CNT_W-1:0]  almost_full_th,
  input  logic [CNT_W-1:0]  almost_empty_th,
  input  logic              err_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              pausa,
  output logic              almost_empty,
  output logic              fifo_error,
  output logic [CNT_W-1:0]  count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              push_acc, pop_acc, ovf, udf;

  always_comb begin
    pop_acc  = pop && (cnt_q != '0);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    push_acc = push && ((cnt_q != FULL_CNT) || pop_acc);
    ovf      = push && !push_acc;
    udf      = pop && (cnt_q == '0);

    wr_ptr_d = push_acc ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_acc  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;

    cnt_d = cnt_q;
    if (push_acc && !pop_acc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_acc && !push_acc) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    valid_d = pop_acc;

    // A fresh error outranks a clear in the same cycle.
    err_d = err_q;
    if (ovf || udf) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .reset_L (reset_L),
    .wr_en   (push_acc),
    .wr_addr (wr_ptr_q),
    .wr_dat  (data_in),
    .rd_en   (pop_acc),
    .rd_addr (rd_ptr_q),
    .rd_dat  (data_out)
  );

  assign valid_out    = valid_q;
  assign fifo_error   = err_q;
  assign count        = cnt_q;
  assign fifo_empty   = (cnt_q == '0);
  assign fifo_full    = (cnt_q == FULL_CNT);
  assign pausa        = (cnt_q >= almost_full_th);
  assign almost_empty = (cnt_q <= almost_empty_th);

endmodule
